// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the serial BCD complement unit.
package bcd_pkg;

    localparam logic       MODE_9S  = 1'b0;
    localparam logic       MODE_10S = 1'b1;
    localparam logic [3:0] BCD_MAX  = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_comp.sv
// Single-digit BCD complement step: y = (9 - x) + ci with decimal carry,
// or 4'hF and inv = 1 for an invalid digit (incoming carry discarded).
// Ports: x digit in, ci carry in, y result digit, co carry out, inv invalid flag.
module bcd_digit_comp
    import bcd_pkg::*;
(
    input  logic [3:0] x,
    input  logic       ci,
    output logic [3:0] y,
    output logic       co,
    output logic       inv
);

    logic [4:0] s;

    always_comb begin
        // s only matters for valid digits, where 9 - x cannot underflow
        s   = 5'(BCD_MAX - x) + 5'(ci);
        y   = s[3:0];
        co  = 1'b0;
        inv = 1'b0;
        if (x > BCD_MAX) begin
            y   = 4'hF;
            inv = 1'b1;
        end else if (s == 5'd10) begin
            y  = 4'd0;
            co = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_comp_serial.sv
// Serial multi-digit BCD 9's/10's complementer, one digit per clock, LSD first.
// Ports: clk, rst (async active-high); in_valid/in_ready with mode and d (operand);
// out_valid/out_ready with C (result), E (per-digit invalid), err (|E), cout.
module bcd_comp_serial
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                mode,
    input  logic [4*DIGITS-1:0] d,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] C,
    output logic [DIGITS-1:0]   E,
    output logic                err,
    output logic                cout
);

    localparam int unsigned W     = 4 * DIGITS;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned LAST  = DIGITS - 1;

    state_t            state, state_nxt;
    logic [W-1:0]      op_q;
    logic              mode_q;
    logic              carry_q;
    logic [IDX_W-1:0]  idx_q;

    logic              accept_c;
    logic              last_c;
    logic [3:0]        digit_c;
    logic [3:0]        y_c;
    logic              co_c;
    logic              inv_c;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign err       = |E;
    assign accept_c  = in_valid & in_ready;
    assign last_c    = (idx_q == IDX_W'(LAST));

    // Select the operand digit addressed by the index counter
    always_comb begin
        digit_c = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) digit_c = op_q[4*i +: 4];
        end
    end

    bcd_digit_comp u_digit (
        .x   (digit_c),
        .ci  (carry_q),
        .y   (y_c),
        .co  (co_c),
        .inv (inv_c)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_c)              state_nxt = RUN;
            RUN:     if (last_c)                state_nxt = DONE;
            DONE:    if (out_valid & out_ready) state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    // Operand capture and per-digit result write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            mode_q  <= MODE_9S;
            carry_q <= 1'b0;
            idx_q   <= '0;
            C       <= '0;
            E       <= '0;
            cout    <= 1'b0;
        end else if (accept_c) begin
            op_q    <= d;
            mode_q  <= mode;
            carry_q <= mode;
            idx_q   <= '0;
            C       <= '0;
            E       <= '0;
            cout    <= 1'b0;
        end else if (state == RUN) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (idx_q == IDX_W'(i)) begin
                    C[4*i +: 4] <= y_c;
                    E[i]        <= inv_c;
                end
            end
            carry_q <= co_c;
            idx_q   <= idx_q + IDX_W'(1);
            if (last_c) cout <= (mode_q == MODE_10S) & co_c;
        end
    end

endmodule

// File: tb/tb_bcd_comp_serial.sv
// Self-checking bench for bcd_comp_serial (DIGITS = 4): directed vector table,
// arithmetic-model random words, backpressure and mid-run reset sequences.
module tb_bcd_comp_serial;

    localparam int unsigned DIGITS = 4;

    typedef struct {
        logic [15:0] d;
        logic        mode;
        logic [15:0] c;
        logic [3:0]  e;
        logic        cout;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        mode;
    logic [15:0] d;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] C;
    logic [3:0]  E;
    logic        err;
    logic        cout;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t sb[$];

    bcd_comp_serial #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .C         (C),
        .E         (E),
        .err       (err),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Drive one word and let it be accepted; the expectation enters the scoreboard
    task automatic start_op(input vec_t v);
        @(negedge clk);
        d        = v.d;
        mode     = v.mode;
        in_valid = 1'b1;
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        sb.push_back(v);
        in_valid = 1'b0;
        d        = 16'($urandom);
        mode     = ~v.mode;
        check("in_ready_after_accept", 32'(in_ready), 32'd0);
    endtask

    // Count edges from accept until out_valid, bounded
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic compare_front(input string tag);
        vec_t v;
        if (sb.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
            return;
        end
        v = sb.pop_front();
        check({tag, "_C"},    32'(C),    32'(v.c));
        check({tag, "_E"},    32'(E),    32'(v.e));
        check({tag, "_err"},  32'(err),  32'(|v.e));
        check({tag, "_cout"}, 32'(cout), 32'(v.cout));
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_out_valid_after_take"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready_after_take"},  32'(in_ready),  32'd1);
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int lat;
        start_op(v);
        wait_done(lat);
        check({tag, "_latency"}, 32'(lat), 32'(DIGITS));
        compare_front(tag);
        handshake(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        vec_t v;
        int   lat;
        int   val;

        vecs[0] = '{16'h1234, 1'b0, 16'h8765, 4'b0000, 1'b0};
        vecs[1] = '{16'h0990, 1'b1, 16'h9010, 4'b0000, 1'b0};
        vecs[2] = '{16'h0000, 1'b1, 16'h0000, 4'b0000, 1'b1};
        vecs[3] = '{16'h12A4, 1'b0, 16'h87F5, 4'b0010, 1'b0};
        vecs[4] = '{16'h00B0, 1'b1, 16'h99F0, 4'b0010, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        mode      = 1'b0;
        d         = '0;
        out_ready = 1'b0;
        #22;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_C",         32'(C),         32'd0);
        check("rst_E",         32'(E),         32'd0);
        check("rst_err",       32'(err),       32'd0);
        check("rst_cout",      32'(cout),      32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // Random all-valid words checked against decimal arithmetic
        for (int i = 0; i < 8; i++) begin
            val    = int'($urandom_range(0, 9999));
            v.d    = to_bcd(val);
            v.mode = 1'($urandom_range(0, 1));
            v.e    = 4'b0000;
            if (v.mode) begin
                v.c    = to_bcd((10000 - val) % 10000);
                v.cout = (val == 0);
            end else begin
                v.c    = to_bcd(9999 - val);
                v.cout = 1'b0;
            end
            run_op(v, $sformatf("rand%0d", i));
        end

        // Backpressure: result held in DONE while a new request waits
        start_op(vecs[0]);
        wait_done(lat);
        check("bp_latency", 32'(lat), 32'(DIGITS));
        in_valid = 1'b1;
        d        = 16'h4321;
        mode     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid_held", 32'(out_valid), 32'd1);
            check("bp_in_ready_low",   32'(in_ready),  32'd0);
            check("bp_C_held",         32'(C),         32'h8765);
            check("bp_E_held",         32'(E),         32'h0);
        end
        compare_front("bp_first");
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_handoff_out_valid", 32'(out_valid), 32'd0);
        check("bp_handoff_in_ready",  32'(in_ready),  32'd1);
        sb.push_back('{16'h4321, 1'b0, 16'h5678, 4'b0000, 1'b0});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_second_accepted", 32'(in_ready), 32'd0);
        wait_done(lat);
        check("bp_second_latency", 32'(lat), 32'(DIGITS));
        compare_front("bp_second");
        handshake("bp_second");

        // Reset mid-RUN after two digits
        start_op(vecs[0]);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("mid_partial_C", 32'(C), 32'h0065);
        rst = 1'b1;
        #1;
        sb.delete();
        check("mid_rst_in_ready",  32'(in_ready),  32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_C",         32'(C),         32'd0);
        check("mid_rst_E",         32'(E),         32'd0);
        check("mid_rst_err",       32'(err),       32'd0);
        check("mid_rst_cout",      32'(cout),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op('{16'h9876, 1'b0, 16'h0123, 4'b0000, 1'b0}, "after_rst");

        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
